// File: rtl/mem_io_responder.sv
// CPU memory/IO responder: RAM pass-through, UART RX/TX byte ports, TX FIFO with back-pressure.
// Optional cycle counter snapshot at 0x30004..0x30007 is built only when CYCLE_COUNTER_EN is defined.
module mem_io_responder #(
  parameter int TX_FIFO_DEPTH = 8,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_RX, SEL_CNT} src_sel_e;

  logic       io_acc, is_uart, is_stop, is_cnt, rd;
  logic [7:0] cnt_byte;
  logic       unused_hi;

  assign unused_hi = ^mem_a[31:18];

  assign io_acc  = (mem_a[17:16] == 2'b11);
  assign is_uart = (mem_a[17:0] == 18'h30000);
  assign is_stop = (mem_a[17:0] == 18'h30004);
  assign is_cnt  = (mem_a[17:2] == 16'hC001);
  assign rd      = !mem_wr;

  assign ram_addr  = mem_a[16:0];
  assign ram_wdata = mem_dout;
  assign ram_we    = mem_wr && !io_acc;
  assign rx_ready  = rd && is_uart && rx_valid;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt, snapshot;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      snapshot  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd && is_cnt && (mem_a[1:0] == 2'd0)) snapshot <= cycle_cnt;
    end
  end

  // Byte 0 returns the live counter because the snapshot is taken in this same cycle.
  always_comb begin
    cnt_byte = 8'h00;
    case (mem_a[1:0])
      2'd0:    cnt_byte = cycle_cnt[7:0];
      2'd1:    cnt_byte = snapshot[15:8];
      2'd2:    cnt_byte = snapshot[23:16];
      default: cnt_byte = snapshot[31:24];
    endcase
  end
`else
  assign cnt_byte = 8'h00;
`endif

  src_sel_e   next_sel, src_sel;
  logic [7:0] next_io, io_rdata, din_hold, resp;
  logic       rd_pend;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    next_sel = SEL_ZERO;
    next_io  = 8'h00;
    if (!io_acc) begin
      next_sel = SEL_RAM;
    end else if (is_uart) begin
      next_sel = SEL_RX;
      next_io  = rx_valid ? rx_data : 8'h00;
    end else if (is_cnt) begin
      next_sel = SEL_CNT;
      next_io  = cnt_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_pend  <= 1'b0;
      src_sel  <= SEL_ZERO;
      io_rdata <= 8'h00;
      din_hold <= 8'h00;
    end else begin
      rd_pend <= rd;
      if (rd) begin
        src_sel  <= next_sel;
        io_rdata <= next_io;
      end
      if (rd_pend) din_hold <= resp;
    end
  end

  // RAM data arrives a cycle late, so it is muxed live and then held once the response cycle ends.
  assign resp    = (src_sel == SEL_RAM) ? ram_rdata : io_rdata;
  assign mem_din = rd_pend ? resp : din_hold;

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push_req, push_ok, pop, full, drop;
  logic [7:0]    push_data;

  assign push_req   = mem_wr && ((is_uart && (mem_dout != 8'h00)) || is_stop);
  assign push_data  = is_uart ? mem_dout : 8'h00;
  assign tx_valid   = (count != '0);
  assign tx_data    = fifo_mem[rd_ptr];
  assign pop        = tx_valid && tx_ready;
  assign full       = (count == CW'(TX_FIFO_DEPTH));
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign count_next = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
      program_stop   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count          <= count_next;
      io_buffer_full <= ((CW'(TX_FIFO_DEPTH) - count_next) <= CW'(FULL_MARGIN));
      if (drop) tx_overflow <= 1'b1;
      if (mem_wr && is_stop) program_stop <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk_in) begin
    if (push_ok && !rst_in) fifo_mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM path, UART RX/TX, back-pressure, counter, stop and reset.
// Counter checks depend on CYCLE_COUNTER_EN being defined for both bench and design.
module tb_mem_io_responder;

  logic        clk_in, rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr, io_buffer_full;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        program_stop, tx_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_model [256];

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Registered RAM: data for an address appears one cycle later.
  always @(posedge clk_in) begin
    if (ram_we) ram_model[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ram_model[ram_addr[7:0]];
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(32'h30000, 1'b1, 8'h55);
    cyc(); cyc();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h want 00", mem_din); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_iobf got %b want 0", io_buffer_full); end
    checks++; if (program_stop !== 1'b0 || tx_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_sticky got stop=%b ovf=%b want 0 0", program_stop, tx_overflow); end
    rst_in = 1'b0;
    drive(32'h0, 1'b0, 8'h00);
    cyc();
  endtask

  task automatic test_ram();
    drive(32'h10, 1'b1, 8'h5A);
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 17'h10 || ram_wdata !== 8'h5A) begin
      errors++; $display("FAIL ram_write got we=%b a=%h d=%h want 1 00010 5a", ram_we, ram_addr, ram_wdata); end
    cyc();
    drive(32'hABC0_0010, 1'b0, 8'h00);
    #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== 17'h00010) begin
      errors++; $display("FAIL ram_read_req got we=%b a=%h want 0 00010", ram_we, ram_addr); end
    cyc();
    checks++; if (mem_din !== 8'h5A) begin errors++; $display("FAIL ram_read got %h want 5a", mem_din); end
    drive(32'h1_0020, 1'b1, 8'h77);
    #1;
    checks++; if (ram_addr !== 17'h10020 || ram_we !== 1'b1) begin
      errors++; $display("FAIL ram_addr16 got a=%h we=%b want 10020 1", ram_addr, ram_we); end
    cyc();
    checks++; if (mem_din !== 8'h5A) begin errors++; $display("FAIL ram_hold got %h want 5a", mem_din); end
    drive(32'h1_0020, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'h77) begin errors++; $display("FAIL ram_read2 got %h want 77", mem_din); end
    drive(32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_uart_tx();
    int hs = 0;
    logic [7:0] last = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(32'h30000, 1'b1, 8'h41);
      else if (i == 1) drive(32'h30000, 1'b1, 8'h00);
      else drive(32'h0, 1'b0, 8'h00);
      if (i == 0) begin
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL io_ram_we got %b want 0", ram_we); end
      end
      cyc();
      if (tx_valid && tx_ready) begin hs++; last = tx_data; end
    end
    checks++; if (hs != 1) begin errors++; $display("FAIL tx_handshakes got %0d want 1", hs); end
    checks++; if (last !== 8'h41) begin errors++; $display("FAIL tx_byte got %h want 41", last); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h33;
    drive(32'h30000, 1'b0, 8'h00);
    #1;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_pulse got %b want 1", rx_ready); end
    cyc();
    drive(32'h30010, 1'b0, 8'h00);
    #1;
    checks++; if (mem_din !== 8'h33) begin errors++; $display("FAIL rx_data got %h want 33", mem_din); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_end got %b want 0", rx_ready); end
    cyc();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL io_other_read got %h want 00", mem_din); end
    rx_data = 8'h55;
    drive(32'h30000, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'h55) begin errors++; $display("FAIL rx_data2 got %h want 55", mem_din); end
    rx_valid = 1'b0; rx_data = 8'h44;
    #1;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_idle got %b want 0", rx_ready); end
    cyc();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty got %h want 00", mem_din); end
    drive(32'h0, 1'b0, 8'h00);
  endtask

`ifdef CYCLE_COUNTER_EN
  task automatic test_counter();
    logic [31:0] snap;
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    repeat (100) cyc();
    snap = 32'h0;
    for (int b = 0; b < 4; b++) begin
      drive(32'h30004 + b, 1'b0, 8'h00);
      cyc();
      snap[8*b +: 8] = mem_din;
    end
    checks++; if (snap !== 32'd100) begin errors++; $display("FAIL counter_snapshot got %0d want 100", snap); end
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    drive(32'h30004, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'hFF) begin errors++; $display("FAIL wrap_byte0 got %h want ff", mem_din); end
    drive(32'h30007, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'hFF) begin errors++; $display("FAIL wrap_byte3 got %h want ff", mem_din); end
    drive(32'h30004, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'h01) begin errors++; $display("FAIL wrap_after got %h want 01", mem_din); end
    drive(32'h30007, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL wrap_after_b3 got %h want 00", mem_din); end
    drive(32'h0, 1'b0, 8'h00);
  endtask
`else
  task automatic test_counter();
    rx_valid = 1'b1; rx_data = 8'h7E;
    drive(32'h30000, 1'b0, 8'h00);
    cyc();
    rx_valid = 1'b0;
    checks++; if (mem_din !== 8'h7E) begin errors++; $display("FAIL cnt_pre got %h want 7e", mem_din); end
    for (int b = 0; b < 4; b++) begin
      drive(32'h30004 + b, 1'b0, 8'h00);
      cyc();
      checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL cnt_off_b%0d got %h want 00", b, mem_din); end
    end
    drive(32'h0, 1'b0, 8'h00);
  endtask
`endif

  task automatic test_back_pressure();
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h30000, 1'b1, 8'(8'h11 + i));
      cyc();
      if (i == 4) begin
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL iobf_5 got %b want 0", io_buffer_full); end
      end
      if (i == 5) begin
        checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL iobf_6 got %b want 1", io_buffer_full); end
      end
      if (i == 7) begin
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_8 got %b want 0", tx_overflow); end
      end
      if (i == 8) begin
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_9 got %b want 1", tx_overflow); end
      end
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) drive(32'h30000, 1'b1, 8'h1A);
      else drive(32'h0, 1'b0, 8'h00);
      exp_b = (k < 8) ? 8'(8'h11 + k) : 8'h1A;
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%h want 1 %h", k, tx_valid, tx_data, exp_b); end
      cyc();
    end
    checks++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      errors++; $display("FAIL drained got v=%b full=%b want 0 0", tx_valid, io_buffer_full); end
  endtask

  task automatic test_stop_reset();
    tx_ready = 1'b1;
    drive(32'h30004, 1'b1, 8'h99);
    cyc();
    drive(32'h0, 1'b0, 8'h00);
    checks++; if (program_stop !== 1'b1) begin errors++; $display("FAIL stop_set got %b want 1", program_stop); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++; $display("FAIL stop_tx got v=%b d=%h want 1 00", tx_valid, tx_data); end
    cyc();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stop_popped got %b want 0", tx_valid); end
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h30000, 1'b1, 8'(8'h21 + i));
      cyc();
    end
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL pre_reset_full got %b want 1", io_buffer_full); end
    drive(32'h30, 1'b1, 8'hA5); cyc();
    drive(32'h31, 1'b1, 8'h5C); cyc();
    drive(32'h30, 1'b0, 8'h00); cyc();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL pre_reset_read got %h want a5", mem_din); end
    rst_in = 1'b1;
    drive(32'h31, 1'b0, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'h00 || tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      errors++; $display("FAIL rst_outs got din=%h v=%b full=%b want 00 0 0", mem_din, tx_valid, io_buffer_full); end
    checks++; if (program_stop !== 1'b0 || tx_overflow !== 1'b0) begin
      errors++; $display("FAIL rst_sticky got stop=%b ovf=%b want 0 0", program_stop, tx_overflow); end
    rst_in = 1'b0;
    drive(32'h40, 1'b1, 8'h00);
    cyc();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rst_inflight got %h want 00", mem_din); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_uart_tx();
    test_rx();
    test_counter();
    test_back_pressure();
    test_stop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
